// File: rtl/err_high_detect_pkg.sv
// ============================================================================
// Module  : err_high_detect_pkg
// Brief   : Shared constants for the err_high_detect fault filter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package err_high_detect_pkg;

    localparam int CNT_W_DEF = 14;
    localparam int DELAY_MIN = 1;
    localparam int DELAY_MAX = 16383;

endpackage

`default_nettype wire

// File: rtl/err_high_detect_sync_ff.sv
// ============================================================================
// Module  : sync_ff
// Brief   : Multi-flop synchronizer for one asynchronous level input.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/err_high_detect.sv
// ============================================================================
// Module  : err_high_detect
// Brief   : Time-filtered high-level fault detector. Define
//           ERR_HIGH_DETECT_LATCH_EN to make signal_out latch until cleared.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module err_high_detect
    import err_high_detect_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             time_1us,
    input  logic             reset_unit,
    input  logic             signal_in,
    output logic             signal_out,
    input  logic [CNT_W-1:0] delay_tims
);

    localparam logic [CNT_W-1:0] DLY_MIN = CNT_W'(DELAY_MIN);

    logic             sig_s;
    logic             time_1us_q;
    logic             tick;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] delay_eff;
    logic [CNT_W:0]   cnt_inc;
    logic             set_cond;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (signal_in),
        .q     (sig_s)
    );

    // A zero delay behaves exactly like the minimum delay of one tick
    assign delay_eff = (delay_tims < DLY_MIN) ? DLY_MIN : delay_tims;
    assign tick      = time_1us & ~time_1us_q;
    assign cnt_inc   = {1'b0, cnt} + 1'b1;
    assign set_cond  = sig_s & tick & (cnt_inc >= {1'b0, delay_eff});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_1us_q <= 1'b0;
        end else begin
            time_1us_q <= time_1us;
        end
    end

    // Counter saturates at the (possibly lowered) delay rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!sig_s) begin
            cnt <= '0;
        end else if (tick) begin
            if (cnt >= delay_eff) begin
                cnt <= delay_eff;
            end else begin
                cnt <= cnt_inc[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signal_out <= 1'b0;
        end else begin
`ifdef ERR_HIGH_DETECT_LATCH_EN
            // Set wins over a simultaneous clear; clear only once the input is low
            if (set_cond) begin
                signal_out <= 1'b1;
            end else if (reset_unit && !sig_s) begin
                signal_out <= 1'b0;
            end
`else
            if (!sig_s) begin
                signal_out <= 1'b0;
            end else if (set_cond) begin
                signal_out <= 1'b1;
            end
`endif
        end
    end

`ifndef ERR_HIGH_DETECT_LATCH_EN
    logic unused_reset_unit;
    assign unused_reset_unit = reset_unit;
`endif

endmodule

`default_nettype wire

// File: tb/tb_err_high_detect.sv
// ============================================================================
// Module  : tb_err_high_detect
// Brief   : Directed self-checking bench for err_high_detect (either build).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_err_high_detect;

    localparam int CNT_W = 14;
`ifdef ERR_HIGH_DETECT_LATCH_EN
    localparam logic LATCH = 1'b1;
`else
    localparam logic LATCH = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             time_1us;
    logic             reset_unit;
    logic             signal_in;
    logic             signal_out;
    logic [CNT_W-1:0] delay_tims;

    int vectors = 0;
    int errs    = 0;

    err_high_detect #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .time_1us   (time_1us),
        .reset_unit (reset_unit),
        .signal_in  (signal_in),
        .signal_out (signal_out),
        .delay_tims (delay_tims)
    );

    always #12.5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Idle gap, then a one-cycle high on time_1us; returns where the result is visible
    task automatic tick(input int gap = 4);
        cycles(gap);
        time_1us = 1'b1;
        @(negedge clk);
        time_1us = 1'b0;
    endtask

    task automatic check(input string tag, input logic exp);
        vectors++;
        assert (signal_out === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, signal_out, exp);
        end
    endtask

    task automatic clear_fault();
        signal_in = 1'b0;
        cycles(3);
        reset_unit = 1'b1;
        cycles(1);
        reset_unit = 1'b0;
        check("clear", 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        time_1us   = 1'b0;
        reset_unit = 1'b0;
        signal_in  = 1'b0;
        delay_tims = 14'd1;
        cycles(3);
        check("reset_state", 1'b0);
        rst_n = 1'b1;

        // delay 1, ticks every 40 clk
        signal_in = 1'b1;
        cycles(3);
        check("d1_presync", 1'b0);
        cycles(30);
        check("d1_no_tick", 1'b0);
        tick(6);
        check("d1_first_tick", 1'b1);
        cycles(40);
        check("d1_hold", 1'b1);

        reset_unit = 1'b1;
        cycles(2);
        reset_unit = 1'b0;
        check("ru_sig_high", 1'b1);

        signal_in = 1'b0;
        cycles(2);
        check("release_stage2", 1'b1);
        cycles(1);
        check("release_stage3", LATCH);
        reset_unit = 1'b1;
        cycles(1);
        reset_unit = 1'b0;
        check("ru_sig_low", 1'b0);

        // delay 5: glitch of 4 ticks rejected, 5 ticks accepted
        delay_tims = 14'd5;
        signal_in  = 1'b1;
        cycles(3);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("d5_glitch", 1'b0);
        end
        signal_in = 1'b0;
        cycles(3);
        check("d5_dropped", 1'b0);
        signal_in = 1'b1;
        cycles(3);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("d5_count", 1'b0);
        end
        tick();
        check("d5_fifth", 1'b1);
        clear_fault();

        // delay 0 behaves as 1
        delay_tims = 14'd0;
        signal_in  = 1'b1;
        cycles(3);
        check("d0_presync", 1'b0);
        tick();
        check("d0_one_tick", 1'b1);
        clear_fault();

        // lowering delay mid-count takes effect on the next tick
        delay_tims = 14'd8;
        signal_in  = 1'b1;
        cycles(3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dchg_count", 1'b0);
        end
        delay_tims = 14'd3;
        tick();
        check("dchg_lowered", 1'b1);
        clear_fault();

        // time_1us stuck high produces no ticks
        delay_tims = 14'd1;
        time_1us   = 1'b1;
        cycles(2);
        signal_in = 1'b1;
        cycles(100);
        check("stuck_tb", 1'b0);
        time_1us = 1'b0;
        cycles(1);
        check("stuck_fall", 1'b0);
        tick();
        check("stuck_recover", 1'b1);
        clear_fault();

        // reset mid-count discards progress
        delay_tims = 14'd10;
        signal_in  = 1'b1;
        cycles(3);
        for (int i = 0; i < 3; i++) tick();
        check("rst_precount", 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid", 1'b0);
        cycles(2);
        rst_n = 1'b1;
        cycles(3);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("rst_recount", 1'b0);
        end
        tick();
        check("rst_tenth", 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", 1'b0);
        cycles(1);
        rst_n     = 1'b1;
        signal_in = 1'b0;
        cycles(3);
        check("final_idle", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/err_high_detect.md
ERR_HIGH_DETECT -- requirements
Module: err_high_detect

Interface
REQ-001 SHALL have parameter CNT_W, default 14, width of delay_tims and the internal tick counter.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on signal_in (legal 2..3).
REQ-003 SHALL have port clk  input  1  single system clock (40 MHz nominal); all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port time_1us  input  1  timebase level, synchronous to clk; each 0->1 transition is one tick.
REQ-006 SHALL have port reset_unit  input  1  synchronous fault-clear request, active-high, level-sensitive.
REQ-007 SHALL have port signal_in  input  1  asynchronous fault input, active-high.
REQ-008 SHALL have port signal_out  output  1  registered fault indication, active-high.
REQ-009 SHALL have port delay_tims  input  CNT_W  required consecutive high ticks, legal 1..16383, quasi-static.

Function
REQ-010 SHALL pass signal_in through SYNC_STAGES flops; sig_s denotes the last stage.
REQ-011 SHALL form tick = time_1us & ~time_1us_q, where time_1us_q is time_1us registered once.
REQ-012 SHALL clear the tick counter on any clk cycle where sig_s = 0, regardless of tick.
REQ-013 SHALL increment the counter by 1 on each tick while sig_s = 1; counter saturates at delay_tims and never wraps.
REQ-014 SHALL set signal_out on the clk edge where sig_s = 1, tick = 1 and counter + 1 >= delay_tims; visible the following cycle.
REQ-015 SHALL treat delay_tims = 0 identically to delay_tims = 1.
REQ-016 SHALL keep signal_out at 0 when sig_s drops low before delay_tims ticks elapse (glitch rejection); the count restarts from 0.
REQ-017 SHALL, with latching enabled, clear signal_out and counter on a clk edge with reset_unit = 1 only when sig_s = 0; with sig_s = 1, reset_unit has no effect.
REQ-018 SHALL, when reset_unit and the set condition of REQ-014 coincide, give set priority (fault stays asserted).
REQ-019 SHALL apply a changed delay_tims from the next tick; a counter already >= the new value asserts on that tick.
REQ-020 SHALL have worst-case assertion latency SYNC_STAGES + 1 clk cycles plus delay_tims ticks from signal_in rising.

Reset
REQ-021 SHALL asynchronously clear, on rst_n = 0: synchronizer flops, time_1us_q, counter and signal_out to 0.
REQ-022 SHALL resume detection from count 0 on the first clk edge after rst_n deasserts; reset mid-count discards progress.

Configuration
REQ-023 SHALL use macro ERR_HIGH_DETECT_LATCH_EN: when defined, signal_out latches per REQ-014/REQ-017.
REQ-024 SHALL, when ERR_HIGH_DETECT_LATCH_EN is undefined, deassert signal_out on the cycle after sig_s = 0 (non-latching, filtered assert, immediate release) and ignore reset_unit.

Structure
REQ-025 SHALL place CNT_W default, DELAY_MIN = 1 and DELAY_MAX = 16383 constants in package err_high_detect_pkg.
REQ-026 SHALL implement the input synchronizer as one sub-module, sync_ff, with async active-low reset; all other logic stays in err_high_detect.

Verification
REQ-027 SHALL verify: delay_tims = 1, signal_in held high, tick every 40 clk -> signal_out = 1 on the cycle after the first tick following sync, latched.
REQ-028 SHALL verify: delay_tims = 5, signal_in high for 4 ticks then low -> signal_out stays 0; rehigh for 5 ticks -> signal_out = 1 after the 5th tick.
REQ-029 SHALL verify: latched fault, reset_unit = 1 with signal_in high -> signal_out stays 1; signal_in low then reset_unit = 1 -> signal_out = 0 next cycle.
REQ-030 SHALL verify: time_1us held constant 1 with signal_in high -> no tick, signal_out stays 0 indefinitely.
REQ-031 SHALL verify: rst_n pulsed low mid-count (3 of 10 ticks) -> signal_out = 0 immediately, 10 further ticks needed after release.
REQ-032 SHALL verify: macro undefined, delay_tims = 2, fault asserted then signal_in low -> signal_out = 0 within SYNC_STAGES + 1 clk cycles.
